// File: rtl/loop_filter_pi_if.sv
// loop_filter_pi_if: phase-detector input, control and frequency-word output bundle of loop_filter_pi.
interface loop_filter_pi_if #(parameter int DW = 26);
    logic signed [DW-1:0] pd;
    logic                 freeze;
    logic                 clear;
    logic signed [DW-1:0] frequency_df;
    logic                 out_valid;
    logic                 sat_flag;
    modport master(output pd, freeze, clear, input frequency_df, out_valid, sat_flag);
    modport slave(input pd, freeze, clear, output frequency_df, out_valid, sat_flag);
endinterface

// File: rtl/loop_filter_pi.sv
// loop_filter_pi: decimating proportional + integral loop filter for carrier recovery.
// Optional saturating adds and sat_flag are enabled by defining LOOPFILTER_SAT_EN; otherwise adds wrap.
module loop_filter_pi #(
    parameter int DW         = 26,
    parameter int C1_SHIFT   = 6,
    parameter int C2_SHIFT   = 13,
    parameter int UPDATE_DIV = 8
) (
    input logic            clk,
    input logic            rst_n,
    loop_filter_pi_if.slave bus
);
    localparam int CW = $clog2(UPDATE_DIV);
    logic [CW-1:0]        cnt;
    logic signed [DW-1:0] sum, pd_reg, freq, sum_nxt, out_nxt;
    logic                 valid_r, sat_r, sat_acc, sum_clip, out_clip;
`ifdef LOOPFILTER_SAT_EN
    logic signed [DW:0] sum_ext, out_ext;
    // One guard bit exposes overflow; clamp toward the sign of the true result.
    always_comb begin
        sum_ext  = (DW+1)'(sum) + (DW+1)'(bus.pd >>> C2_SHIFT);
        out_ext  = (DW+1)'(sum) + (DW+1)'(pd_reg >>> C1_SHIFT);
        sum_clip = sum_ext[DW] ^ sum_ext[DW-1];
        out_clip = out_ext[DW] ^ out_ext[DW-1];
        sum_nxt  = sum_clip ? {sum_ext[DW], {(DW-1){~sum_ext[DW]}}} : sum_ext[DW-1:0];
        out_nxt  = out_clip ? {out_ext[DW], {(DW-1){~out_ext[DW]}}} : out_ext[DW-1:0];
    end
`else
    always_comb begin
        sum_clip = 1'b0;
        out_clip = 1'b0;
        sum_nxt  = sum + (bus.pd >>> C2_SHIFT);
        out_nxt  = sum + (pd_reg >>> C1_SHIFT);
    end
`endif
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            cnt     <= '0;
            sum     <= '0;
            pd_reg  <= '0;
            freq    <= '0;
            valid_r <= 1'b0;
            sat_r   <= 1'b0;
            sat_acc <= 1'b0;
        end else begin
            cnt     <= (cnt == CW'(UPDATE_DIV - 1)) ? '0 : cnt + 1'b1;
            valid_r <= (cnt == CW'(1));
            if (cnt == '0) begin
                pd_reg  <= bus.pd;
                sat_acc <= !bus.freeze && sum_clip;
                if (!bus.freeze)
                    sum <= sum_nxt;
            end
            if (cnt == CW'(1)) begin
                freq  <= out_nxt;
                sat_r <= sat_acc | out_clip;
            end
        end
    end
    assign bus.frequency_df = freq;
    assign bus.out_valid    = valid_r;
    assign bus.sat_flag     = sat_r;
endmodule

// File: tb/tb_loop_filter_pi.sv
// tb_loop_filter_pi: table-driven, hand-sequenced and randomized checks of loop_filter_pi
// at default parameters and at DW=16/C1=2/C2=8/DIV=2, against an arithmetic reference model.
module tb_loop_filter_pi;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    loop_filter_pi_if #(.DW(26)) a_if();
    loop_filter_pi_if #(.DW(16)) b_if();

    loop_filter_pi #(.DW(26), .C1_SHIFT(6), .C2_SHIFT(13), .UPDATE_DIV(8))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    loop_filter_pi #(.DW(16), .C1_SHIFT(2), .C2_SHIFT(8), .UPDATE_DIV(2))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

    int n_cmp = 0, n_err = 0;
    int     dw[2]  = '{26, 16};
    int     c1s[2] = '{6, 2};
    int     c2s[2] = '{13, 8};
    int     div[2] = '{8, 2};
    longint m_sum[2] = '{0, 0};

    typedef struct {
        longint pd;
        bit     frz;
        longint exp;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // floor(x / 2^s) by integer division
    function automatic longint fdiv(longint x, int s);
        longint d = longint'(1) << s;
        return (x >= 0) ? x / d : -((-x + d - 1) / d);
    endfunction

    function automatic longint fit(longint x, int w, output bit clip);
        longint hi = (longint'(1) << (w - 1)) - 1;
        longint lo = -hi - 1;
        longint m  = longint'(1) << w;
`ifdef LOOPFILTER_SAT_EN
        clip = (x > hi) || (x < lo);
        return (x > hi) ? hi : (x < lo) ? lo : x;
`else
        clip = 1'b0;
        return (((x - lo) % m) + m) % m + lo;
`endif
    endfunction

    function automatic longint rnd(int s);
        return longint'($signed($urandom)) >>> (32 - dw[s]);
    endfunction

    function automatic longint freq(int s);
        return (s == 0) ? longint'(a_if.frequency_df) : longint'(b_if.frequency_df);
    endfunction

    function automatic longint valid(int s);
        return (s == 0) ? longint'(a_if.out_valid) : longint'(b_if.out_valid);
    endfunction

    function automatic longint satf(int s);
        return (s == 0) ? longint'(a_if.sat_flag) : longint'(b_if.sat_flag);
    endfunction

    task automatic drive(int s, longint p, bit frz);
        if (s == 0) begin
            a_if.pd = p[25:0];
            a_if.freeze = frz;
        end else begin
            b_if.pd = p[15:0];
            b_if.freeze = frz;
        end
    endtask

    // One update period: junk on pd/freeze in idle cycles, p/frz only at the ACC edge.
    task automatic period(int s, longint p, bit frz, int idle, string name, output longint act);
        bit ca, co;
        longint exp;
        for (int i = 0; i < idle; i++) begin
            drive(s, rnd(s), 1'($urandom));
            @(negedge clk);
            chk({name, " idle valid"}, valid(s), 0);
        end
        drive(s, p, frz);
        @(negedge clk);
        chk({name, " acc valid"}, valid(s), 0);
        ca = 1'b0;
        if (!frz) m_sum[s] = fit(m_sum[s] + fdiv(p, c2s[s]), dw[s], ca);
        exp = fit(m_sum[s] + fdiv(p, c1s[s]), dw[s], co);
        drive(s, rnd(s), 1'($urandom));
        @(negedge clk);
        act = freq(s);
        chk({name, " out valid"}, valid(s), 1);
        chk({name, " freq"}, act, exp);
        chk({name, " sat"}, satf(s), longint'(ca | co));
    endtask

    task automatic do_clear(int s);
        @(negedge clk);
        if (s == 0) begin a_if.clear = 1'b1; a_if.freeze = 1'b1; end
        else begin b_if.clear = 1'b1; b_if.freeze = 1'b1; end
        @(negedge clk);
        chk("clear freq", freq(s), 0);
        chk("clear valid", valid(s), 0);
        chk("clear sat", satf(s), 0);
        if (s == 0) a_if.clear = 1'b0; else b_if.clear = 1'b0;
        m_sum[s] = 0;
    endtask

    initial begin
        longint act;
        bit seen;
        tbl[0]  = '{8192, 1'b0, 130};
        tbl[1]  = '{8192, 1'b0, 131};
        tbl[2]  = '{8192, 1'b0, 132};
        tbl[3]  = '{8192, 1'b0, 133};
        tbl[4]  = '{8192, 1'b1, 133};
        tbl[5]  = '{8192, 1'b1, 133};
        tbl[6]  = '{8192, 1'b0, 134};
        tbl[7]  = '{8192, 1'b0, 135};
        tbl[8]  = '{0, 1'b1, 7};
        tbl[9]  = '{-1, 1'b0, 5};
        tbl[10] = '{-8192, 1'b0, -123};
        tbl[11] = '{-8193, 1'b0, -126};
        tbl[12] = '{100000, 1'b1, 1565};

        rst_n = 1'b0;
        a_if.clear = 1'b0;
        b_if.clear = 1'b0;
        drive(0, 8192, 1'b0);
        drive(1, 256, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset freq", freq(0), 0);
            chk("reset valid", valid(0), 0);
            chk("reset sat", satf(0), 0);
        end
        rst_n = 1'b1;
        period(0, 8192, 1'b0, 0, "first", act);
        chk("first value", act, 129);

        for (int i = 0; i < 13; i++) begin
            period(0, tbl[i].pd, tbl[i].frz, 6, "table", act);
            chk($sformatf("table[%0d]", i), act, tbl[i].exp);
        end

        period(0, 8192, 1'b0, 6, "pre-clear", act);
        period(0, 8192, 1'b0, 6, "pre-clear", act);
        chk("pre-clear sum5", act, 133);
        do_clear(0);
        period(0, 8192, 1'b0, 0, "post-clear", act);
        chk("post-clear value", act, 129);

        do_clear(0);
        for (int k = 1; k <= 4; k++) begin
            period(0, -1, 1'b0, (k == 1) ? 0 : 6, "neg floor", act);
            chk($sformatf("neg floor k=%0d", k), act, -(k + 1));
        end

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset freq", freq(0), 0);
        chk("midreset valid", valid(0), 0);
        rst_n = 1'b1;
        m_sum[0] = 0;
        period(0, 8192, 1'b0, 0, "midreset", act);
        chk("midreset value", act, 129);

        for (int i = 0; i < 150; i++)
            period(0, rnd(0), ($urandom_range(3) == 0), 6, "rand A", act);

        do_clear(1);
        period(1, 256, 1'b0, 0, "sweep", act);
        chk("sweep first", act, 65);
        for (int k = 2; k <= 6; k++) begin
            period(1, 256, 1'b0, 0, "sweep", act);
            chk($sformatf("sweep k=%0d", k), act, 64 + k);
        end
        for (int i = 0; i < 60; i++)
            period(1, rnd(1), ($urandom_range(3) == 0), 0, "rand B", act);

        do_clear(1);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            period(1, 32767, 1'b0, 0, "sat run", act);
`ifdef LOOPFILTER_SAT_EN
            if (act == 32767 && satf(1) == 1) seen = 1'b1;
`else
            if (act < 0) seen = 1'b1;
`endif
        end
        chk("overflow boundary reached", longint'(seen), 1);
        period(1, 0, 1'b0, 0, "sat release", act);
        chk("sat release flag", satf(1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/loop_filter_pi.md
# loop_filter_pi

Parametrised second-order (proportional + integral) loop filter for the carrier-recovery loops (Costas / PLL).
- Takes the signed phase-detector output every clock and updates a decimated frequency-correction word once per `UPDATE_DIV` clocks.
- Sits between the phase detector and the NCO frequency input.
- Adds over the fixed 26-bit filter: programmable width, gains and update period; freeze and clear controls; an output-valid strobe; optional saturating arithmetic.

## Interface
- `DW`, 26: data width of `pd`, the integrator and `frequency_df` (two's complement).
- `C1_SHIFT`, 6: proportional gain exponent, c1 = 2^-C1_SHIFT; range 0..DW-1.
- `C2_SHIFT`, 13: integral gain exponent, c2 = 2^-C2_SHIFT; range 0..DW-1.
- `UPDATE_DIV`, 8: clocks per update period; must be ≥2.
- `clk`  in  1: system clock; all logic on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `pd`  in  DW: signed phase-error sample; valid every clock.
- `freeze`  in  1: while high, the integrator holds; the proportional path still updates.
- `clear`  in  1: synchronous clear of the integrator, output and phase counter.
- `frequency_df`  out  DW: signed filtered frequency word.
- `out_valid`  out  1: one-clock pulse coincident with each new `frequency_df`.
- `sat_flag`  out  1: the last update clipped (see Configuration).

## Operation
- The phase counter `cnt` counts 0..UPDATE_DIV-1 and wraps to 0.
- `cnt==0` (ACC phase):
  - `pd_reg` <= `pd`.
  - Unless `freeze`: `sum` <= `sum` + (`pd` >>> C2_SHIFT).
- `cnt==1` (OUT phase):
  - `frequency_df` <= `sum` + (`pd_reg` >>> C1_SHIFT).
  - `out_valid` <= 1. It is 0 in every other cycle.
  - `sat_flag` <= the OR of integrator and output clipping from this period's ACC and OUT phases.
- Other `cnt` values: idle; all registers hold.
- Shifts are arithmetic, so they floor toward −inf (e.g. -1 >>> 13 = -1).
- Adds are DW-bit signed. Overflow handling is set by the macro in Configuration.
- `clear` is sampled every clock.
  - When high: `sum`, `pd_reg`, `frequency_df`, `sat_flag` <= 0; `cnt` <= 0; `out_valid` <= 0.
  - The first ACC phase after `clear` drops is the cycle in which `clear` is first seen low.
- `clear` and `freeze` together: `clear` wins.
- `freeze` is sampled only in the ACC phase; toggling it in other phases has no effect.

## Timing
- Reset (`rst_n` low at a rising edge): every register is zeroed, i.e. `frequency_df`=0, `out_valid`=0, `sat_flag`=0, `sum`=0, `cnt`=0.
- The first ACC phase occurs at the first edge with `rst_n` high.
- Reset mid-period abandons the partial update; no `out_valid` is emitted for it.
- Latency: `pd` sampled at the ACC edge appears in `frequency_df` one clock later, at the OUT edge. `out_valid` rises at that same edge.
- Throughput: one output per UPDATE_DIV clocks. `out_valid` pulses are exactly UPDATE_DIV clocks apart while no reset or `clear` occurs.
- `frequency_df` is stable between OUT edges.
- `pd` samples in non-ACC cycles are ignored; decimation is by subsampling, not averaging.

## Configuration
- Macro: `LOOPFILTER_SAT_EN`.
- Defined: the integrator add and the output add saturate to [-2^(DW-1), 2^(DW-1)-1]. `sat_flag` is set on any clip.
- Undefined: both adds wrap modulo 2^DW, and `sat_flag` is tied to 0. This is bit-exact with the legacy 26-bit filter for default parameters.

## Test plan
Defaults apply unless stated.
- Reset: hold `rst_n`=0 for 3 clocks with `pd`=8192.
  - During reset: `frequency_df`=0, `out_valid`=0.
  - After release: first `out_valid` 2 clocks later with `frequency_df`=129 (sum=1, prop=128).
  - Thereafter `frequency_df`=k+128 on the k-th pulse, every 8 clocks.
- Negative floor: `pd`=-1 constant → `frequency_df` = -(k+1) on the k-th pulse, e.g. -2 on the first.
- Freeze: run `pd`=8192 until `frequency_df`=133 (sum=5), then set `freeze`=1 → `frequency_df` stays 133 on every later pulse. Release → 134, 135, …
- Clear mid-period: assert `clear` for one clock at `cnt`=3 while sum=5.
  - Next clock: `frequency_df`=0, no `out_valid` in that period.
  - The next pulse comes 2 clocks after `clear` falls, with value 129.
- Saturation: `pd`=33554431 (2^25-1, so `pd` >>> 13 = 4095) for 8200 periods.
  - With the macro: `frequency_df` clamps at 33554431 and `sat_flag`=1. Then `pd`=0 → `sat_flag` clears on the next pulse.
  - Without the macro: the integrator wraps negative, crossing to ≤ -33554432+4095, and `sat_flag` stays 0.
- Parameter sweep: DW=16, C1_SHIFT=2, C2_SHIFT=8, UPDATE_DIV=2, `pd`=256 → pulses every 2 clocks; first `frequency_df`=65, then 66, 67, …
